mem_stage: RTL

Memory-access stage of the five-stage MIPS pipeline, between the execute stage and the write-back stage. It registers the execute-stage payload and aligns/extends load data returned by the data SRAM, including the lb/lbu/lh/lhu/lw/lwl/lwr merges. It drives the valid/allowin handshake and the `MS_TO_WS_BUS_WD` bus consumed by write-back. It also publishes a forwarding bus for the decode stage.

---
 rtl/mem_stage.sv | 83 ++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage; registers the execute payload and aligns/extends load data.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   es_to_ms_valid/bus    instruction from execute {ld_op, gr_we, dest, rt_value, alu_result, pc}
//   ms_allowin            stage can accept a new instruction
//   ws_allowin            write-back can accept
//   ms_to_ws_valid/bus    instruction to write-back {rf_we, dest, final_result, pc}
//   data_sram_rdata       load data, valid in the first cycle a load sits here
//   ms_to_ds_bus          forwarding to decode {ld_pending, fwd_we, dest, final_result}
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    output logic         ms_allowin,
    input  logic         es_to_ms_valid,
    input  logic [108:0] es_to_ms_bus,
    input  logic         ws_allowin,
    output logic         ms_to_ws_valid,
    output logic [72:0]  ms_to_ws_bus,
    input  logic [31:0]  data_sram_rdata,
    output logic [41:0]  ms_to_ds_bus
);
    logic         ms_valid_q, ms_valid_d;
    logic [108:0] bus_q, bus_d;
    logic         buf_valid_q, buf_valid_d;
    logic [31:0]  rdata_buf_q, rdata_buf_d;
    logic [6:0]   ld_op;
    logic         gr_we;
    logic [4:0]   dest;
    logic [31:0]  rt, alu, pc, d, lwl_v, lwr_v, final_result;
    logic [1:0]   a;
    logic [7:0]   byte_v;
    logic [15:0]  half_v;
    logic [3:0]   lwl_we, lwr_we, rf_we;
    logic         capture;

    assign {ld_op, gr_we, dest, rt, alu, pc} = bus_q;
    assign a = alu[1:0];

    always_comb begin
        ms_allowin  = !ms_valid_q || ws_allowin;
        ms_valid_d  = ms_allowin ? es_to_ms_valid : ms_valid_q;
        bus_d       = (es_to_ms_valid && ms_allowin) ? es_to_ms_bus : bus_q;
        // SRAM data is only guaranteed in the first cycle; hold it across a stall
        capture     = ms_valid_q && !ws_allowin && !buf_valid_q;
        rdata_buf_d = capture ? data_sram_rdata : rdata_buf_q;
        buf_valid_d = (ms_valid_q && ws_allowin) ? 1'b0 : capture ? 1'b1 : buf_valid_q;
        d           = buf_valid_q ? rdata_buf_q : data_sram_rdata;
        byte_v      = a == 2'd0 ? d[7:0] : a == 2'd1 ? d[15:8] : a == 2'd2 ? d[23:16] : d[31:24];
        half_v      = a[1] ? d[31:16] : d[15:0];
        lwl_v       = a == 2'd0 ? {d[7:0], rt[23:0]} : a == 2'd1 ? {d[15:0], rt[15:0]} :
                      a == 2'd2 ? {d[23:0], rt[7:0]} : d;
        lwr_v       = a == 2'd0 ? d : a == 2'd1 ? {rt[31:24], d[31:8]} :
                      a == 2'd2 ? {rt[31:16], d[31:16]} : {rt[31:8], d[31:24]};
        lwl_we      = a == 2'd0 ? 4'b1000 : a == 2'd1 ? 4'b1100 : a == 2'd2 ? 4'b1110 : 4'b1111;
        lwr_we      = a == 2'd0 ? 4'b1111 : a == 2'd1 ? 4'b0111 : a == 2'd2 ? 4'b0011 : 4'b0001;
        final_result = ld_op[6] ? d :
                       ld_op[5] ? {{24{byte_v[7]}}, byte_v} :
                       ld_op[4] ? {24'd0, byte_v} :
                       ld_op[3] ? {{16{half_v[15]}}, half_v} :
                       ld_op[2] ? {16'd0, half_v} :
                       ld_op[1] ? lwl_v :
                       ld_op[0] ? lwr_v : alu;
        rf_we       = !gr_we ? 4'b0000 : ld_op[1] ? lwl_we : ld_op[0] ? lwr_we : 4'b1111;
        ms_to_ws_valid = ms_valid_q;
        ms_to_ws_bus   = {rf_we, dest, final_result, pc};
        ms_to_ds_bus   = {ms_valid_q && (ld_op != 7'd0), rf_we & {4{ms_valid_q}}, dest, final_result};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q  <= 1'b0;
            buf_valid_q <= 1'b0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        bus_q       <= bus_d;
        rdata_buf_q <= rdata_buf_d;
    end
endmodule
